// File: rtl/present_pkg.sv
// PRESENT cipher shared definitions: nibble S-boxes, FSM states, bit permutation.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package present_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PREKEY,
        ENC,
        DEC,
        DONE
    } fsm_e;

    localparam logic [3:0] SBOX [16] = '{
        4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
        4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
    };

    localparam logic [3:0] SBOX_INV [16] = '{
        4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
        4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA
    };

    // Destination of source bit j. Forward sends j to 16j mod 63; inverse sends
    // j to 4j mod 63 (4 is the inverse of 16 modulo 63). Bit 63 never moves.
    function automatic int perm_idx(input int j, input logic inv);
        if (j == 63) return 63;
        return inv ? ((4 * j) % 63) : ((16 * j) % 63);
    endfunction

    function automatic logic [63:0] perm_layer(input logic [63:0] x, input logic inv);
        logic [63:0] y;
        y = '0;
        for (int j = 0; j < 64; j++) y[perm_idx(j, inv)] = x[j];
        return y;
    endfunction

endpackage

// File: rtl/present_sbox_layer.sv
// Parallel 4-bit S-box lookups, forward or inverse.
// Latency: combinational.
// Backpressure: n/a.
module present_sbox_layer
    import present_pkg::*;
#(
    parameter int NIBBLES = 16
) (
    input  logic                   inverse,
    input  logic [4*NIBBLES-1:0]   din,
    output logic [4*NIBBLES-1:0]   dout
);

    // Independent lookup per nibble; table chosen by direction.
    always_comb begin
        dout = '0;
        for (int n = 0; n < NIBBLES; n++) begin
            dout[4*n +: 4] = inverse ? SBOX_INV[din[4*n +: 4]] : SBOX[din[4*n +: 4]];
        end
    end

endmodule

// File: rtl/present_round_engine.sv
// Iterative PRESENT encrypt/decrypt, one round per clock, 80/128-bit key.
// Latency: accept to out_valid is ROUNDS+1 (encrypt) or 2*ROUNDS+1 (decrypt) cycles.
// Backpressure: one block in flight; in_ready only in IDLE, result held until out_ready.
module present_round_engine
    import present_pkg::*;
#(
    parameter int KEY_BITS = 80,
    parameter int ROUNDS   = 31
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_decrypt,
    input  logic [63:0]         in_block,
    input  logic [KEY_BITS-1:0] in_key,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [63:0]         out_block,
    output logic                busy
);

    if (!(KEY_BITS == 80 || KEY_BITS == 128)) begin : g_bad_key
        $error("present_round_engine: KEY_BITS must be 80 or 128");
    end
    if (ROUNDS < 1 || ROUNDS > 31) begin : g_bad_rounds
        $error("present_round_engine: ROUNDS must be in 1..31");
    end

    // Round counter lands at bits [19:15] (80) or [66:62] (128); 128-bit keys
    // pass two nibbles through the S-box instead of one.
    localparam int CPOS = (KEY_BITS == 128) ? 62 : 15;
    localparam int KN   = (KEY_BITS == 128) ? 2 : 1;
    localparam int KW   = 4 * KN;

    fsm_e                fsm_q, fsm_d;
    logic [63:0]         blk_q, blk_d;
    logic [KEY_BITS-1:0] key_q, key_d;
    logic [4:0]          cnt_q, cnt_d;
    logic [63:0]         out_block_q, out_block_d;
    logic                out_valid_q, out_valid_d;
    logic                in_ready_q, in_ready_d;
    logic                busy_q, busy_d;

    logic                is_dec, dec_first;
    logic [63:0]         rk_cur, rk_nxt;
    logic [KEY_BITS-1:0] ctr_mask, key_rot, key_x, key_fwd, key_inv_pre, key_inv, key_nxt;
    logic [KW-1:0]       ksb_in, ksb_out;
    logic [63:0]         dec_src, sb_in, sb_out, enc_round, dec_round;

    // Key schedule step: forward (rotate, S-box, add counter) or its exact reverse.
    always_comb begin
        is_dec      = (fsm_q == DEC);
        rk_cur      = key_q[KEY_BITS-1 -: 64];
        ctr_mask    = KEY_BITS'(cnt_q) << CPOS;
        key_rot     = (key_q << 61) | (key_q >> (KEY_BITS - 61));
        key_x       = key_q ^ ctr_mask;
        ksb_in      = is_dec ? key_x[KEY_BITS-1 -: KW] : key_rot[KEY_BITS-1 -: KW];
        key_fwd     = {ksb_out, key_rot[KEY_BITS-KW-1:0]} ^ ctr_mask;
        key_inv_pre = {ksb_out, key_x[KEY_BITS-KW-1:0]};
        key_inv     = (key_inv_pre >> 61) | (key_inv_pre << (KEY_BITS - 61));
        key_nxt     = is_dec ? key_inv : key_fwd;
        rk_nxt      = key_nxt[KEY_BITS-1 -: 64];
    end

    present_sbox_layer #(.NIBBLES(KN)) u_key_sbox (
        .inverse (is_dec),
        .din     (ksb_in),
        .dout    (ksb_out)
    );

    // Round datapath; the first decrypt cycle also strips the final whitening key.
    always_comb begin
        dec_first = is_dec && (cnt_q == 5'(ROUNDS));
        dec_src   = blk_q ^ (dec_first ? rk_cur : 64'd0);
        sb_in     = is_dec ? perm_layer(dec_src, 1'b1) : (blk_q ^ rk_cur);
        enc_round = perm_layer(sb_out, 1'b0);
        dec_round = sb_out ^ rk_nxt;
    end

    present_sbox_layer #(.NIBBLES(16)) u_state_sbox (
        .inverse (is_dec),
        .din     (sb_in),
        .dout    (sb_out)
    );

    // Next-state and registered-output logic for the block FSM.
    always_comb begin
        fsm_d       = fsm_q;
        blk_d       = blk_q;
        key_d       = key_q;
        cnt_d       = cnt_q;
        out_block_d = out_block_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
        busy_d      = busy_q;
        case (fsm_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    blk_d      = in_block;
                    key_d      = in_key;
                    cnt_d      = 5'd1;
                    fsm_d      = in_decrypt ? PREKEY : ENC;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            PREKEY: begin
                key_d = key_nxt;
                // Counter stays at ROUNDS: the first decrypt round undoes update ROUNDS.
                if (cnt_q == 5'(ROUNDS)) fsm_d = DEC;
                else                     cnt_d = cnt_q + 5'd1;
            end
            ENC: begin
                key_d = key_nxt;
                if (cnt_q == 5'(ROUNDS)) begin
                    blk_d = enc_round ^ rk_nxt;
                    fsm_d = DONE;
                end else begin
                    blk_d = enc_round;
                    cnt_d = cnt_q + 5'd1;
                end
            end
            DEC: begin
                key_d = key_nxt;
                blk_d = dec_round;
                if (cnt_q == 5'd1) fsm_d = DONE;
                else               cnt_d = cnt_q - 5'd1;
            end
            DONE: begin
                // Result is copied to the output register once, then held until taken.
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                    out_block_d = blk_q;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    busy_d      = 1'b0;
                    fsm_d       = IDLE;
                end
            end
            default: begin
                fsm_d      = IDLE;
                in_ready_d = 1'b1;
                busy_d     = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any block in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q       <= IDLE;
            blk_q       <= '0;
            key_q       <= '0;
            cnt_q       <= '0;
            out_block_q <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            blk_q       <= blk_d;
            key_q       <= key_d;
            cnt_q       <= cnt_d;
            out_block_q <= out_block_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_block = out_block_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_present_round_engine.sv
// Self-checking bench for present_round_engine with 80- and 128-bit key instances.
// Latency: n/a.
// Backpressure: exercises held results, ignored in_valid and mid-round reset.
module tb_present_round_engine;

    localparam int R = 31;

    logic         clk;
    logic         rst_n;
    logic         in_valid   [2];
    logic         in_ready   [2];
    logic         in_decrypt [2];
    logic [63:0]  in_block   [2];
    logic [127:0] in_key     [2];
    logic         out_valid  [2];
    logic         out_ready  [2];
    logic [63:0]  out_block  [2];
    logic         busy       [2];

    int vectors     = 0;
    int miscompares = 0;

    present_round_engine #(.KEY_BITS(80), .ROUNDS(R)) dut80 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid[0]),
        .in_ready   (in_ready[0]),
        .in_decrypt (in_decrypt[0]),
        .in_block   (in_block[0]),
        .in_key     (in_key[0][79:0]),
        .out_valid  (out_valid[0]),
        .out_ready  (out_ready[0]),
        .out_block  (out_block[0]),
        .busy       (busy[0])
    );

    present_round_engine #(.KEY_BITS(128), .ROUNDS(R)) dut128 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid[1]),
        .in_ready   (in_ready[1]),
        .in_decrypt (in_decrypt[1]),
        .in_block   (in_block[1]),
        .in_key     (in_key[1]),
        .out_valid  (out_valid[1]),
        .out_ready  (out_ready[1]),
        .out_block  (out_block[1]),
        .busy       (busy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] sb(input logic [3:0] x);
        logic [63:0] tbl;
        tbl = 64'hC56B90AD3EF84712;
        return tbl[(15 - int'(x)) * 4 +: 4];
    endfunction

    function automatic logic [3:0] sbi(input logic [3:0] x);
        for (int v = 0; v < 16; v++) if (sb(4'(v)) == x) return 4'(v);
        return 4'h0;
    endfunction

    // Reference: expand all round keys up front, then run the rounds forward or backward.
    function automatic logic [63:0] ref_present(input logic [63:0] blk, input logic [127:0] key,
                                                input bit k128, input bit dec);
        int           kb;
        logic [127:0] k, t;
        logic [63:0]  rk [1:R+1];
        logic [63:0]  s, u;
        kb = k128 ? 128 : 80;
        k  = k128 ? key : {48'd0, key[79:0]};
        for (int r = 1; r <= R + 1; r++) begin
            rk[r] = 64'(k >> (kb - 64));
            t = '0;
            for (int b = 0; b < kb; b++) t[(b + 61) % kb] = k[b];
            k = t;
            k[kb-4 +: 4] = sb(k[kb-4 +: 4]);
            if (k128) k[kb-8 +: 4] = sb(k[kb-8 +: 4]);
            k = k ^ (128'(r) << (k128 ? 62 : 15));
        end
        if (!dec) begin
            s = blk;
            for (int r = 1; r <= R; r++) begin
                s = s ^ rk[r];
                for (int n = 0; n < 16; n++) s[4*n +: 4] = sb(s[4*n +: 4]);
                u = '0;
                for (int j = 0; j < 64; j++) u[(j == 63) ? 63 : (16 * j) % 63] = s[j];
                s = u;
            end
            return s ^ rk[R+1];
        end
        s = blk ^ rk[R+1];
        for (int r = R; r >= 1; r--) begin
            u = '0;
            for (int j = 0; j < 64; j++) u[j] = s[(j == 63) ? 63 : (16 * j) % 63];
            s = u;
            for (int n = 0; n < 16; n++) s[4*n +: 4] = sbi(s[4*n +: 4]);
            s = s ^ rk[r];
        end
        return s;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge just after the accept edge; returns cycles until out_valid.
    task automatic wait_out(input int u, output int lat);
        lat = 0;
        while (!out_valid[u] && lat < 300) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic do_block(input int u, input bit dec, input logic [63:0] blk,
                            input logic [127:0] key, input logic [63:0] exp,
                            input string tag, output logic [63:0] res);
        int n;
        int lat;
        n = 0;
        while (!in_ready[u] && n < 200) begin
            @(negedge clk);
            n++;
        end
        in_valid[u]   = 1'b1;
        in_decrypt[u] = dec;
        in_block[u]   = blk;
        in_key[u]     = key;
        @(posedge clk);
        @(negedge clk);
        in_valid[u] = 1'b0;
        wait_out(u, lat);
        chk({tag, "_lat"}, 64'(lat), 64'(dec ? 2 * R + 1 : R + 1));
        res = out_block[u];
        chk(tag, res, exp);
        out_ready[u] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready[u] = 1'b0;
    endtask

    initial begin
        logic [63:0]  res, res2, blk, blk_b, exp_v;
        logic [127:0] key;
        int           lat, seen;

        rst_n = 1'b0;
        for (int u = 0; u < 2; u++) begin
            in_valid[u]   = 1'b0;
            in_decrypt[u] = 1'b0;
            in_block[u]   = '0;
            in_key[u]     = '0;
            out_ready[u]  = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            chk("rst_in_ready",  64'(in_ready[u]),  64'd1);
            chk("rst_out_valid", 64'(out_valid[u]), 64'd0);
            chk("rst_busy",      64'(busy[u]),      64'd0);
            chk("rst_out_block", out_block[u],      64'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        // Known-answer vectors.
        do_block(0, 1'b0, 64'h0, 128'h0, 64'h5579C1387B228445, "kat80_enc_zero", res);
        do_block(0, 1'b0, 64'hFFFFFFFFFFFFFFFF, 128'hFFFFFFFFFFFFFFFFFFFF,
                 64'h3333DCD3213210D2, "kat80_enc_ones", res);
        do_block(0, 1'b0, 64'h0, 128'hFFFFFFFFFFFFFFFFFFFF,
                 64'hE72C46C0F5945049, "kat80_enc_key1", res);
        do_block(0, 1'b1, 64'hA112FFC72F68417B, 128'h0,
                 64'hFFFFFFFFFFFFFFFF, "kat80_dec", res);
        do_block(1, 1'b0, 64'h0, 128'h0, 64'h96DB702A2E6900AF, "kat128_enc_zero", res);
        do_block(1, 1'b1, res, 128'h0, 64'h0, "kat128_dec_zero", res2);

        // Backpressure: result held, in_valid ignored while DONE.
        blk   = {$urandom, $urandom};
        key   = {48'd0, $urandom, $urandom, 16'($urandom)};
        exp_v = ref_present(blk, key, 1'b0, 1'b0);
        in_valid[0] = 1'b1; in_decrypt[0] = 1'b0; in_block[0] = blk; in_key[0] = key;
        @(posedge clk);
        @(negedge clk);
        in_valid[0] = 1'b0;
        wait_out(0, lat);
        chk("bp_lat", 64'(lat), 64'(R + 1));
        chk("bp_result", out_block[0], exp_v);
        in_valid[0] = 1'b1; in_decrypt[0] = 1'b1; in_block[0] = ~blk;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            @(negedge clk);
            chk("bp_hold_block", out_block[0], exp_v);
            chk("bp_hold_in_ready", 64'(in_ready[0]), 64'd0);
            chk("bp_hold_valid", 64'(out_valid[0]), 64'd1);
        end
        // Handshake with in_valid still high: accept must wait one cycle.
        blk_b = {$urandom, $urandom};
        in_block[0] = blk_b; in_decrypt[0] = 1'b0;
        out_ready[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready[0] = 1'b0;
        chk("hs_out_valid", 64'(out_valid[0]), 64'd0);
        chk("hs_busy_idle", 64'(busy[0]), 64'd0);
        chk("hs_in_ready", 64'(in_ready[0]), 64'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid[0] = 1'b0;
        chk("hs_busy_accept", 64'(busy[0]), 64'd1);
        wait_out(0, lat);
        chk("hs_lat", 64'(lat), 64'(R + 1));
        chk("hs_result", out_block[0], ref_present(blk_b, key, 1'b0, 1'b0));
        out_ready[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready[0] = 1'b0;

        // Reset during round 12 of an encryption.
        in_valid[0] = 1'b1; in_decrypt[0] = 1'b0; in_block[0] = blk; in_key[0] = key;
        @(posedge clk);
        @(negedge clk);
        in_valid[0] = 1'b0;
        repeat (11) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_in_ready", 64'(in_ready[0]), 64'd1);
        chk("mid_rst_busy", 64'(busy[0]), 64'd0);
        chk("mid_rst_out_block", out_block[0], 64'd0);
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            if (out_valid[0]) seen = 1;
            @(negedge clk);
        end
        chk("mid_rst_no_output", 64'(seen), 64'd0);
        do_block(0, 1'b0, blk, key, exp_v, "post_rst_enc", res);

        // Randomised round trips, 80-bit key.
        for (int i = 0; i < 150; i++) begin
            blk = {$urandom, $urandom};
            key = {48'd0, $urandom, $urandom, 16'($urandom)};
            do_block(0, 1'b0, blk, key, ref_present(blk, key, 1'b0, 1'b0), "rnd80_enc", res);
            do_block(0, 1'b1, res, key, blk, "rnd80_roundtrip", res2);
        end
        // Randomised direct decrypts, 80-bit key.
        for (int i = 0; i < 30; i++) begin
            blk = {$urandom, $urandom};
            key = {48'd0, $urandom, $urandom, 16'($urandom)};
            do_block(0, 1'b1, blk, key, ref_present(blk, key, 1'b0, 1'b1), "rnd80_dec", res);
        end
        // Randomised round trips, 128-bit key.
        for (int i = 0; i < 20; i++) begin
            blk = {$urandom, $urandom};
            key = {$urandom, $urandom, $urandom, $urandom};
            do_block(1, 1'b0, blk, key, ref_present(blk, key, 1'b1, 1'b0), "rnd128_enc", res);
            do_block(1, 1'b1, res, key, blk, "rnd128_roundtrip", res2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
